// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and
// the priority encoder that picks one cause when several sources fire at once.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StLock  = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2,
    StRun   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CausePor  = 2'd0,
    CauseLock = 2'd1,
    CauseBtn  = 2'd2,
    CauseSw   = 2'd3
  } cause_e;

  // Lock loss beats the button, which beats the software request.
  function automatic cause_e src_cause(logic lock_ok, logic btn, logic sw);
    if (!lock_ok) return CauseLock;
    if (btn) return CauseBtn;
    if (sw) return CauseSw;
    return CausePor;
  endfunction

endpackage

// File: rtl/reset_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to
// ResetVal so the downstream logic sees a defined value during reset.
module reset_seq_sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: merges POR, PLL lock loss, button and software reset into one
// registered active-high reset. Optional button debounce via RSTSEQ_DEBOUNCE_EN.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 160000,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned DEB_CYCLES  = 1600000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       inp_resn,
  input  logic       pll_locked,
  input  logic       btn_resn,
  input  logic       sw_res,
  output logic       res_out,
  output logic       ready,
  output logic [1:0] cause
);

  localparam logic [CNT_W-1:0] LockLoad = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

  logic             lock_s;
  logic             btn_s;
  logic             btn_src;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_q;
  logic             ready_q;
  cause_e           cause_q;

  reset_seq_sync_2ff #(
    .ResetVal(1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(inp_resn),
    .d    (pll_locked),
    .q    (lock_s)
  );

  reset_seq_sync_2ff #(
    .ResetVal(1'b1)
  ) u_btn_sync (
    .clk  (clk),
    .rst_n(inp_resn),
    .d    (btn_resn),
    .q    (btn_s)
  );

`ifdef RSTSEQ_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DebLoad = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt_q;
  logic             btn_deb_q;

  // Button counts only after DEB_CYCLES consecutive low samples; registered so
  // the FSM never sees a combinational glitch from the counter compare.
  always_ff @(posedge clk or negedge inp_resn) begin
    if (!inp_resn) begin
      deb_cnt_q <= DebLoad;
      btn_deb_q <= 1'b0;
    end else begin
      btn_deb_q <= !btn_s && (deb_cnt_q == '0);
      if (btn_s) begin
        deb_cnt_q <= DebLoad;
      end else if (deb_cnt_q != '0) begin
        deb_cnt_q <= deb_cnt_q - CNT_W'(1);
      end
    end
  end

  assign btn_src = btn_deb_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign btn_src    = !btn_s;
`endif

  always_ff @(posedge clk or negedge inp_resn) begin
    if (!inp_resn) begin
      state_q <= StLock;
      cnt_q   <= LockLoad;
      res_q   <= 1'b1;
      ready_q <= 1'b0;
      cause_q <= CausePor;
    end else begin
      res_q   <= 1'b1;
      ready_q <= 1'b0;
      case (state_q)
        StLock: begin
          if (!lock_s) begin
            cnt_q <= LockLoad;
          end else if (cnt_q == '0) begin
            state_q <= StHold;
            cnt_q   <= HoldLoad;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StHold: begin
          if (!lock_s) begin
            state_q <= StLock;
            cnt_q   <= LockLoad;
            cause_q <= CauseLock;
          end else if (btn_src) begin
            cnt_q   <= HoldLoad;
            cause_q <= CauseBtn;
          end else begin
            // A held software request is parked in StDrain once the hold expires.
            if (sw_res) cause_q <= CauseSw;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if (sw_res) begin
              state_q <= StDrain;
            end else begin
              state_q <= StRun;
              res_q   <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (!lock_s) begin
            state_q <= StLock;
            cnt_q   <= LockLoad;
            cause_q <= CauseLock;
          end else if (!sw_res) begin
            state_q <= StHold;
            cnt_q   <= HoldLoad;
          end
        end
        StRun: begin
          if (!lock_s || btn_src || sw_res) begin
            cause_q <= src_cause(lock_s, btn_src, sw_res);
            if (!lock_s) begin
              state_q <= StLock;
              cnt_q   <= LockLoad;
            end else begin
              state_q <= StHold;
              cnt_q   <= HoldLoad;
            end
          end else begin
            res_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StLock;
          cnt_q   <= LockLoad;
        end
      endcase
    end
  end

  assign res_out = res_q;
  assign ready   = ready_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: scenarios push the expected output changes
// (cycle, res_out, ready, cause) computed from the latency rules; a monitor pops them.
module tb_reset_seq;

  localparam int unsigned Hold = 16;
  localparam int unsigned Lock = 8;
  localparam int unsigned Deb  = 32;

  logic       clk = 1'b0;
  logic       inp_resn;
  logic       pll_locked;
  logic       btn_resn;
  logic       sw_res;
  logic       res_out;
  logic       ready;
  logic [1:0] cause;

  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    string       name;
    int unsigned at;
    logic        res;
    logic        rdy;
    logic [1:0]  cse;
  } ev_t;

  ev_t exp_q[$];

  reset_seq #(
    .HOLD_CYCLES(Hold),
    .LOCK_STABLE(Lock),
    .DEB_CYCLES (Deb),
    .CNT_W      (24)
  ) dut (
    .clk       (clk),
    .inp_resn  (inp_resn),
    .pll_locked(pll_locked),
    .btn_resn  (btn_resn),
    .sw_res    (sw_res),
    .res_out   (res_out),
    .ready     (ready),
    .cause     (cause)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next expected event.
  initial begin
    logic [3:0] prev;
    ev_t        e;
    prev = 4'b1000;
    forever begin
      @(negedge clk);
      if ({res_out, ready, cause} !== prev) begin
        prev = {res_out, ready, cause};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected change: cycle %0d res_out=%b ready=%b cause=%0d, none required",
                   cyc, res_out, ready, cause);
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || e.res !== res_out || e.rdy !== ready || e.cse !== cause) begin
            mismatched++;
            $display("FAIL %s: got cycle %0d res_out=%b ready=%b cause=%0d, required cycle %0d res_out=%b ready=%b cause=%0d",
                     e.name, cyc, res_out, ready, cause, e.at, e.res, e.rdy, e.cse);
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(int unsigned run_at);
    tick(int'(run_at) - int'(cyc) + 2);
  endtask

  task automatic push(string name, int unsigned at, logic r, logic y, logic [1:0] c);
    ev_t e;
    e.name = name;
    e.at   = at;
    e.res  = r;
    e.rdy  = y;
    e.cse  = c;
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [1:0] got, logic [1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Release reset with the PLL locked: 2 sync cycles, Lock stable samples, Hold cycles.
  task automatic por();
    int unsigned k;
    k = cyc;
    push("por_release", k + 2 + Lock + Hold, 1'b0, 1'b1, 2'd0);
    inp_resn = 1'b1;
    settle(k + 2 + Lock + Hold);
  endtask

  // PLL unlocked for d cycles; optionally a 1-cycle sw_res that lands on the same FSM cycle.
  task automatic lock_drop(int d, bit with_sw);
    int unsigned k;
    int          last;
    k = cyc;
    push("lock_assert", k + 3, 1'b1, 1'b0, 2'd1);
    push("lock_release", k + d + 2 + Lock + Hold, 1'b0, 1'b1, 2'd1);
    pll_locked = 1'b0;
    last = (d > 3) ? d : 3;
    for (int i = 1; i <= last; i++) begin
      tick(1);
      if (i == d) pll_locked = 1'b1;
      if (with_sw && i == 2) sw_res = 1'b1;
      if (with_sw && i == 3) sw_res = 1'b0;
    end
    settle(k + d + 2 + Lock + Hold);
  endtask

  // sw_res high for w cycles; if it outlives the hold it is drained, then a full hold follows.
  task automatic sw_pulse(int w);
    int unsigned k;
    int unsigned run;
    k = cyc;
    run = (w <= int'(Hold)) ? k + Hold + 1 : k + w + Hold + 1;
    push("sw_assert", k + 1, 1'b1, 1'b0, 2'd3);
    push("sw_release", run, 1'b0, 1'b1, 2'd3);
    sw_res = 1'b1;
    tick(w);
    sw_res = 1'b0;
    settle(run);
  endtask

  task automatic btn_pulse(int w);
    int unsigned k;
    int unsigned run;
    k = cyc;
`ifdef RSTSEQ_DEBOUNCE_EN
    if (w >= int'(Deb)) begin
      run = k + w + 3 + Hold;
      push("btn_deb_assert", k + Deb + 3, 1'b1, 1'b0, 2'd2);
      push("btn_deb_release", run, 1'b0, 1'b1, 2'd2);
    end else begin
      run = k + w + 3;
    end
`else
    run = k + w + 2 + Hold;
    push("btn_assert", k + 3, 1'b1, 1'b0, 2'd2);
    push("btn_release", run, 1'b0, 1'b1, 2'd2);
`endif
    btn_resn = 1'b0;
    tick(w);
    btn_resn = 1'b1;
    settle(run);
  endtask

  // Button and software reset aligned so both reach the FSM on the same cycle.
  task automatic btn_sw(int w);
    int unsigned k;
    int unsigned run;
    k = cyc;
`ifdef RSTSEQ_DEBOUNCE_EN
    run = k + 3 + Hold;
    push("btn_sw_assert", k + 3, 1'b1, 1'b0, 2'd3);
    push("btn_sw_release", run, 1'b0, 1'b1, 2'd3);
`else
    run = k + w + 2 + Hold;
    push("btn_sw_assert", k + 3, 1'b1, 1'b0, 2'd2);
    push("btn_sw_release", run, 1'b0, 1'b1, 2'd2);
`endif
    btn_resn = 1'b0;
    tick(2);
    sw_res = 1'b1;
    tick(w - 2);
    btn_resn = 1'b1;
    tick(2);
    sw_res = 1'b0;
    settle(run);
  endtask

  task automatic reset_mid_hold();
    int unsigned k;
    k = cyc;
    push("mid_hold_sw", k + 1, 1'b1, 1'b0, 2'd3);
    sw_res = 1'b1;
    tick(1);
    sw_res = 1'b0;
    tick(3);
    push("mid_hold_async_reset", cyc, 1'b1, 1'b0, 2'd0);
    inp_resn = 1'b0;
    #1;
    check("async_reset_res_out", {1'b0, res_out}, 2'd1);
    check("async_reset_ready", {1'b0, ready}, 2'd0);
    check("async_reset_cause", cause, 2'd0);
    tick(3);
    por();
  endtask

  initial begin
    inp_resn   = 1'b1;
    pll_locked = 1'b1;
    btn_resn   = 1'b1;
    sw_res     = 1'b0;
    #1 inp_resn = 1'b0;
    #1;
    check("reset_res_out", {1'b0, res_out}, 2'd1);
    check("reset_ready", {1'b0, ready}, 2'd0);
    check("reset_cause", cause, 2'd0);
    tick(2);
    por();
    lock_drop(1, 1'b0);
    sw_pulse(40);
    btn_sw(3);
`ifdef RSTSEQ_DEBOUNCE_EN
    btn_pulse(20);
    btn_pulse(40);
`endif
    lock_drop(1, 1'b1);
    reset_mid_hold();
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 4))
        0: lock_drop(int'($urandom_range(1, 5)), 1'b0);
        1: sw_pulse(int'($urandom_range(1, 40)));
`ifdef RSTSEQ_DEBOUNCE_EN
        2: btn_pulse(int'($urandom_range(1, 45)));
`else
        2: btn_pulse(int'($urandom_range(1, 5)));
`endif
        3: btn_sw(int'($urandom_range(2, 5)));
        default: lock_drop(1, 1'b1);
      endcase
      tick(int'($urandom_range(1, 8)));
    end
    tick(4);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
